alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational Hack ALU between `N_REQ` requesters. Each requester submits an operand pair plus the six Hack control bits through a valid/ready handshake. The block registers the granted operation onto the ALU ports, captures `out`/`zr`/`ng`, and returns the result with the requester ID through a valid/ready response channel. It sits between the instruction/datapath clients and the existing ALU.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational Hack ALU.
// One operation in flight: accept -> exec -> response.
module alu_arbiter #(
    parameter  int WIDTH = 16,
    parameter  int N_REQ = 2,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_x_i,
    input  logic [N_REQ*WIDTH-1:0] req_y_i,
    input  logic [N_REQ*6-1:0]     req_ctrl_i,
    output logic [WIDTH-1:0]       alu_x_o,
    output logic [WIDTH-1:0]       alu_y_o,
    output logic                   alu_zx_o,
    output logic                   alu_nx_o,
    output logic                   alu_zy_o,
    output logic                   alu_ny_o,
    output logic                   alu_f_o,
    output logic                   alu_no_o,
    input  logic [WIDTH-1:0]       alu_out_i,
    input  logic                   alu_zr_i,
    input  logic                   alu_ng_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [WIDTH-1:0]       rsp_out_o,
    output logic                   rsp_zr_o,
    output logic                   rsp_ng_o,
    output logic                   busy_o,
    output logic [15:0]            op_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   gnt;
    logic [IDW-1:0]   rr_next;
    logic [IDW:0]     cand;
    logic             gnt_vld;
    logic             accept;
    logic             capture;
    logic             retire;
    logic [WIDTH-1:0] x_q, y_q, out_q;
    logic [WIDTH-1:0] sel_x, sel_y;
    logic [5:0]       ctrl_q, sel_ctrl;
    logic             zr_q, ng_q;
    logic [15:0]      op_cnt_q;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin : rr_search
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ))
                cand = cand - (IDW+1)'(N_REQ);
            if (!gnt_vld && req_valid_i[cand[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt     = cand[IDW-1:0];
            end
        end
    end

    always_comb begin : req_mux
        sel_x    = '0;
        sel_y    = '0;
        sel_ctrl = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt == IDW'(k)) begin
                sel_x    = req_x_i[k*WIDTH +: WIDTH];
                sel_y    = req_y_i[k*WIDTH +: WIDTH];
                sel_ctrl = req_ctrl_i[k*6 +: 6];
            end
        end
    end

    assign rr_next = (gnt == IDW'(N_REQ-1)) ? '0 : gnt + 1'b1;

    always_comb begin : fsm_next
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready_o = N_REQ'(1) << gnt;
                    accept      = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ctrl_q   <= '0;
            out_q    <= '0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
            op_cnt_q <= '0;
        end else begin
            if (accept) begin
                x_q      <= sel_x;
                y_q      <= sel_y;
                ctrl_q   <= sel_ctrl;
                id_q     <= gnt;
                rr_ptr_q <= rr_next;
            end
            if (capture) begin
                out_q <= alu_out_i;
                zr_q  <= alu_zr_i;
                ng_q  <= alu_ng_i;
            end
            if (retire)
                op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign alu_x_o    = x_q;
    assign alu_y_o    = y_q;
    assign alu_zx_o   = ctrl_q[5];
    assign alu_nx_o   = ctrl_q[4];
    assign alu_zy_o   = ctrl_q[3];
    assign alu_ny_o   = ctrl_q[2];
    assign alu_f_o    = ctrl_q[1];
    assign alu_no_o   = ctrl_q[0];
    assign rsp_id_o   = id_q;
    assign rsp_out_o  = out_q;
    assign rsp_zr_o   = zr_q;
    assign rsp_ng_o   = ng_q;
    assign busy_o     = (state_q != IDLE);
    assign op_count_o = op_cnt_q;

endmodule
